aes_axil_regs: RTL and testbench
================================

# aes_axil_regs

AXI4-Lite slave register block for the AES system: the responder end of the S00_AXI interface driven by the system master. It exposes control, status, 128-bit key, 128-bit input block and 128-bit result registers. It hands key and data to the AES core with a start/done handshake and captures the core's result. It sits between the AXI interconnect and the AES core inside the AES_system IP.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; 14 word registers are used.
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- S_AXI_AWADDR  in  6  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARADDR  in  6  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- aes_key  out  128  key; KEY0 maps to bits [127:96].
- aes_din  out  128  input block; DIN0 maps to bits [127:96].
- aes_mode  out  1  0 = encrypt, 1 = decrypt.
- aes_start  out  1  one-cycle start pulse to the core.
- aes_done  in  1  one-cycle completion pulse from the core.
- aes_dout  in  128  core result; valid in the aes_done cycle.
- irq  out  1  level interrupt (see Configuration).

## Operation
- Register map, word offsets:
  - 0x00 CTRL: bit0 START is write-1, self-clearing, and reads 0. bit1 MODE is R/W. bit2 IRQ_EN is R/W.
  - 0x04 STATUS (RO except W1C): bit0 BUSY, bit1 DONE.
  - 0x08–0x14: KEY0–3, R/W.
  - 0x18–0x24: DIN0–3, R/W.
  - 0x28–0x34: DOUT0–3, RO.
- Offsets 0x38–0x3C are unmapped. Reads there return 0 with SLVERR. Writes there are ignored and return SLVERR.
- Writes to DOUT are ignored and return SLVERR. Writes to STATUS return OKAY.
- Address bits [1:0] are ignored.
- R/W registers honour WSTRB per byte. Byte 0 must be strobed for a CTRL START/MODE/IRQ_EN update or a STATUS W1C to take effect.
- Write channel:
  - AW and W are accepted independently. Each is latched in its own holding register.
  - AWREADY = 1 while no address is held and BVALID = 0. WREADY = 1 while no data is held and BVALID = 0.
  - Once both address and data are held, the next edge performs the commit: register update, BVALID = 1, BRESP set, and both holding registers cleared.
  - BVALID holds until the BREADY handshake.
- Read channel:
  - ARREADY = 1 while RVALID = 0.
  - On the handshake edge, RDATA, RRESP and RVALID = 1 are registered.
  - RDATA and RRESP are held stable until the RREADY handshake.
- Core handshake:
  - A CTRL write with START = 1 while BUSY = 0 raises aes_start for exactly one cycle, starting the cycle after the commit. BUSY sets on that same edge.
  - START written while BUSY = 1 is ignored. The write still returns OKAY and the MODE field still updates.
  - On aes_done with BUSY = 1, on the same edge: DOUT ← aes_dout, BUSY ← 0, DONE ← 1.
  - aes_done while BUSY = 0 is ignored.
  - DONE is sticky. Writing STATUS with bit1 = 1 clears it.
  - If aes_done and the W1C land on the same edge, the set wins.
- aes_key, aes_din and aes_mode are direct register outputs. Software must not change them while BUSY = 1; the block does not block such writes.

## Timing
- Reset values while S_AXI_ARESETN = 0 at an edge:
  - All registers, holding registers and outputs are 0.
  - AWREADY, WREADY and ARREADY are 0 during reset and rise on the first edge after reset deasserts.
- Reset mid-transaction drops any held address or data, any pending BVALID/RVALID, and BUSY. aes_done arriving during reset is ignored.
- Write latency: AW and W valid together → handshake at edge 0 → commit and BVALID at edge 1.
- Read latency: ARVALID → handshake at edge 0 → RVALID at edge 1.
- Back-to-back reads with RREADY = 1 sustain one read per two cycles.
- Reads and writes are fully independent. A read of STATUS in the commit cycle of a W1C returns the pre-write value.

## Configuration
- AES_AXIL_IRQ_EN defined:
  - CTRL bit2 IRQ_EN is implemented.
  - irq = DONE & IRQ_EN, registered, so it rises the cycle after DONE sets.
- AES_AXIL_IRQ_EN undefined:
  - CTRL bit2 reads 0 and ignores writes.
  - irq is tied to 0.
  - All other behaviour is identical.

## Test plan
- Key readback: write 0x1, 0x2, 0x3, 0x4 to 0x08–0x14 with WSTRB = F. Read back → each value matches, RRESP = 00. aes_key = 0x00000001_00000002_00000003_00000004.
- Split and strobed write: drive W 3 cycles before AW, 0xAABBCCDD to 0x18 with WSTRB = 0x5. Prior value is 0 → DIN0 = 0x00BB00DD, BVALID exactly one cycle after the AW handshake.
- Start/done: write CTRL = 0x3 → aes_start one-cycle pulse, aes_mode = 1, STATUS = 0x1. Drive aes_done with aes_dout = 0x0123…CDEF → STATUS = 0x2, DOUT0 = 0x01234567. A second START while busy produces no pulse.
- DONE collision: assert aes_done on the same edge as a STATUS W1C of 0x2 → DONE remains 1. A subsequent W1C → STATUS = 0.
- Error and backpressure: write to 0x28 and 0x38, read from 0x3C → SLVERR, DOUT unchanged, RDATA = 0. Hold BREADY/RREADY low 5 cycles → BVALID/RVALID and data stable, AWREADY and ARREADY low until the handshake.
- IRQ, only with AES_AXIL_IRQ_EN: IRQ_EN = 1, complete an operation → irq = 1 one cycle after DONE sets. W1C → irq = 0. Reset mid-operation → BUSY = 0, irq = 0.

Source files
------------

// File: rtl/aes_axil_regs_if.sv
// aes_axil_regs_if: AXI4-Lite bus from the system master to the AES register block (master/slave modports)
interface aes_axil_regs_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/aes_axil_regs.sv
// aes_axil_regs: AXI4-Lite CTRL/STATUS/KEY/DIN/DOUT registers feeding the AES core (ports: S_AXI_ACLK, S_AXI_ARESETN, s_axi slave bus, aes_key/aes_din/aes_mode/aes_start/aes_done/aes_dout core handshake, irq; define AES_AXIL_IRQ_EN to implement CTRL.IRQ_EN and irq)
module aes_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic           S_AXI_ACLK,
  input  logic           S_AXI_ARESETN,
  aes_axil_regs_if.slave s_axi,
  output logic [127:0]   aes_key,
  output logic [127:0]   aes_din,
  output logic           aes_mode,
  output logic           aes_start,
  input  logic           aes_done,
  input  logic [127:0]   aes_dout,
  output logic           irq
);
  localparam logic [1:0] SLVERR = 2'b10;
  logic up, aw_held, w_held, busy, done, irq_en, wr, unused;
  logic [3:0] aw_idx, ar_idx, w_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data, rd_word;
  logic [127:0] dout;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction
  // word 0 of a 128-bit register sits in bits [127:96]
  function automatic logic [31:0] word(input logic [127:0] v, input logic [1:0] k);
    return v[{~k, 5'd0} +: 32];
  endfunction
  assign unused = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
  assign ar_idx = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  // up keeps the ready lines low until the first edge after reset releases
  assign s_axi.awready = up & ~aw_held & ~s_axi.bvalid;
  assign s_axi.wready = up & ~w_held & ~s_axi.bvalid;
  assign s_axi.arready = up & ~s_axi.rvalid;
  assign wr = aw_held & w_held;
  always_comb
    rd_word = ar_idx == 4'd0 ? {29'd0, irq_en, aes_mode, 1'b0} :
              ar_idx == 4'd1 ? {30'd0, done, busy} :
              ar_idx < 4'd6  ? word(aes_key, 2'(ar_idx - 4'd2)) :
              ar_idx < 4'd10 ? word(aes_din, 2'(ar_idx - 4'd6)) :
              ar_idx < 4'd14 ? word(dout, 2'(ar_idx - 4'd10)) : 32'd0;
`ifndef AES_AXIL_IRQ_EN
  assign irq_en = 1'b0;
  assign irq = 1'b0;
`endif
  always_ff @(posedge S_AXI_ACLK)
    if (!S_AXI_ARESETN) begin
      {up, aw_held, w_held, busy, done, aes_mode, aes_start} <= '0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      aes_key <= '0;
      aes_din <= '0;
      dout <= '0;
      s_axi.bvalid <= 1'b0;
      s_axi.bresp <= '0;
      s_axi.rvalid <= 1'b0;
      s_axi.rdata <= '0;
      s_axi.rresp <= '0;
`ifdef AES_AXIL_IRQ_EN
      irq_en <= 1'b0;
      irq <= 1'b0;
`endif
    end else begin
      up <= 1'b1;
      aes_start <= 1'b0;
      if (s_axi.awvalid & s_axi.awready) begin
        aw_held <= 1'b1;
        aw_idx <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (s_axi.wvalid & s_axi.wready) begin
        w_held <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (s_axi.bvalid & s_axi.bready) s_axi.bvalid <= 1'b0;
      if (wr) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_axi.bvalid <= 1'b1;
        s_axi.bresp <= aw_idx >= 4'd10 ? SLVERR : 2'b00;
        for (int i = 0; i < 4; i++) begin
          if (aw_idx == 4'(2 + i)) aes_key[32*(3-i) +: 32] <= merge(aes_key[32*(3-i) +: 32], w_data, w_strb);
          if (aw_idx == 4'(6 + i)) aes_din[32*(3-i) +: 32] <= merge(aes_din[32*(3-i) +: 32], w_data, w_strb);
        end
        if (aw_idx == 4'd0 && w_strb[0]) begin
          aes_mode <= w_data[1];
`ifdef AES_AXIL_IRQ_EN
          irq_en <= w_data[2];
`endif
          if (w_data[0] && !busy) begin
            aes_start <= 1'b1;
            busy <= 1'b1;
          end
        end
        if (aw_idx == 4'd1 && w_strb[0] && w_data[1]) done <= 1'b0;
      end
      // completion comes after the W1C so a same-edge set wins
      if (aes_done && busy) begin
        dout <= aes_dout;
        busy <= 1'b0;
        done <= 1'b1;
      end
`ifdef AES_AXIL_IRQ_EN
      irq <= done & irq_en;
`endif
      if (s_axi.arvalid & s_axi.arready) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata <= rd_word;
        s_axi.rresp <= ar_idx >= 4'd14 ? SLVERR : 2'b00;
      end else if (s_axi.rvalid & s_axi.rready) s_axi.rvalid <= 1'b0;
    end
endmodule

// File: tb/tb_aes_axil_regs.sv
// tb_aes_axil_regs: randomized and directed checks of aes_axil_regs against a register-level model
module tb_aes_axil_regs;
`ifdef AES_AXIL_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 0, rstn = 0, aes_done = 0, aes_mode, aes_start, irq;
  logic [127:0] aes_dout = '0, aes_key, aes_din;
  int pass_n = 0, total_n = 0, cyc = 0, starts_seen = 0, starts_m = 0, last_lat, s0;
  bit chk_en = 0, prev_start = 0, mode_m, ien_m, busy_m, done_m;
  logic [31:0] key_m [4], din_m [4], dout_m [4], d;
  logic [1:0] last_resp, last_rresp;
  logic [127:0] v;
  always #5 clk = ~clk;
  aes_axil_regs_if bus();
  aes_axil_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .s_axi(bus),
    .aes_key(aes_key), .aes_din(aes_din), .aes_mode(aes_mode), .aes_start(aes_start),
    .aes_done(aes_done), .aes_dout(aes_dout), .irq(irq)
  );
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] dd, input logic [3:0] s);
    logic [31:0] m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (dd & m);
  endfunction
  function automatic logic [31:0] exp_rd(input logic [5:0] a);
    int k = int'(a[5:2]);
    if (k == 0) return {29'd0, IRQ & ien_m, mode_m, 1'b0};
    if (k == 1) return {30'd0, done_m, busy_m};
    if (k < 6) return key_m[k-2];
    if (k < 10) return din_m[k-6];
    if (k < 14) return dout_m[k-10];
    return 32'd0;
  endfunction
  task automatic m_write(input logic [5:0] a, input logic [31:0] dd, input logic [3:0] s, output logic [1:0] r);
    int k = int'(a[5:2]);
    r = k >= 10 ? 2'b10 : 2'b00;
    if (k == 0 && s[0]) begin
      if (dd[0] && !busy_m) begin busy_m = 1; starts_m++; end
      mode_m = dd[1];
      if (IRQ) ien_m = dd[2];
    end
    if (k == 1 && s[0] && dd[1]) done_m = 0;
    if (k >= 2 && k < 6) key_m[k-2] = bmerge(key_m[k-2], dd, s);
    if (k >= 6 && k < 10) din_m[k-6] = bmerge(din_m[k-6], dd, s);
  endtask
  task automatic m_done(input logic [127:0] x);
    if (busy_m) begin
      busy_m = 0;
      done_m = 1;
      for (int i = 0; i < 4; i++) dout_m[i] = x[127-32*i -: 32];
    end
  endtask
  always @(negedge clk) begin
    if (aes_start) begin
      starts_seen <= starts_seen + 1;
      chk("start_width", prev_start, 0);
    end
    prev_start <= aes_start;
    if (chk_en) begin
      chk("aes_key", aes_key, {key_m[0], key_m[1], key_m[2], key_m[3]});
      chk("aes_din", aes_din, {din_m[0], din_m[1], din_m[2], din_m[3]});
      chk("aes_mode", aes_mode, mode_m);
      chk("irq", irq, IRQ & done_m & ien_m);
      chk("aes_start_idle", aes_start, 0);
    end
  end
  task automatic axi_write(input logic [5:0] a, input logic [31:0] dd, input logic [3:0] s,
                           input int awd, input int wd, input int hold, output logic [1:0] r, output int lat);
    int n = 0, c_aw = 0;
    bit a_ok = 0, w_ok = 0;
    bus.awaddr = a; bus.wdata = dd; bus.wstrb = s;
    while (!(a_ok && w_ok) && n < 50) begin
      bus.awvalid = !a_ok && n >= awd;
      bus.wvalid = !w_ok && n >= wd;
      if (bus.awvalid && bus.awready) begin a_ok = 1; c_aw = cyc + 1; end
      if (bus.wvalid && bus.wready) w_ok = 1;
      @(negedge clk); n++;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    while (!bus.bvalid && n < 100) begin @(negedge clk); n++; end
    chk("write_timeout", n >= 100, 0);
    lat = cyc - c_aw;
    r = bus.bresp;
    for (int i = 0; i < hold; i++) begin
      chk("awready_hold", bus.awready, 0);
      chk("wready_hold", bus.wready, 0);
      @(negedge clk);
      chk("bvalid_hold", bus.bvalid, 1);
      chk("bresp_hold", bus.bresp, r);
    end
    bus.bready = 1;
    @(negedge clk);
    bus.bready = 0;
  endtask
  task automatic do_write(input logic [5:0] a, input logic [31:0] dd, input logic [3:0] s,
                          input int awd = 0, input int wd = 0, input int hold = 0);
    logic [1:0] er;
    chk_en = 0;
    axi_write(a, dd, s, awd, wd, hold, last_resp, last_lat);
    m_write(a, dd, s, er);
    chk($sformatf("bresp_%0h", a), last_resp, er);
    chk_en = 1;
  endtask
  task automatic do_read(input logic [5:0] a, output logic [31:0] dd, input int hold = 0);
    int n = 0;
    bus.araddr = a; bus.arvalid = 1;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.arvalid = 0;
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    chk("read_timeout", n >= 50, 0);
    dd = bus.rdata;
    last_rresp = bus.rresp;
    for (int i = 0; i < hold; i++) begin
      chk("arready_hold", bus.arready, 0);
      @(negedge clk);
      chk("rvalid_hold", bus.rvalid, 1);
      chk("rdata_hold", bus.rdata, dd);
      chk("rresp_hold", bus.rresp, last_rresp);
    end
    bus.rready = 1;
    @(negedge clk);
    bus.rready = 0;
    chk($sformatf("rdata_%0h", a), dd, exp_rd(a));
    chk($sformatf("rresp_%0h", a), last_rresp, a[5:2] >= 4'd14 ? 2'b10 : 2'b00);
  endtask
  task automatic core_done(input logic [127:0] x);
    chk_en = 0;
    aes_done = 1; aes_dout = x;
    @(negedge clk);
    aes_done = 0;
    @(negedge clk);
    m_done(x);
    chk_en = 1;
  endtask
  task automatic do_reset(input bit pulse);
    chk_en = 0;
    rstn = 0; aes_done = pulse; aes_dout = '1;
    repeat (3) @(negedge clk);
    aes_done = 0;
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_key", aes_key, 0);
    chk("rst_din", aes_din, 0);
    chk("rst_start", aes_start, 0);
    chk("rst_irq", irq, 0);
    for (int i = 0; i < 4; i++) begin key_m[i] = 0; din_m[i] = 0; dout_m[i] = 0; end
    {mode_m, ien_m, busy_m, done_m} = 0;
    rstn = 1;
    chk("release_awready", bus.awready, 0);
    @(negedge clk);
    chk("up_awready", bus.awready, 1);
    chk("up_wready", bus.wready, 1);
    chk("up_arready", bus.arready, 1);
    chk_en = 1;
  endtask
  initial begin
    {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} = 0;
    bus.awaddr = 0; bus.araddr = 0; bus.awprot = 0; bus.arprot = 0; bus.wdata = 0; bus.wstrb = 0;
    do_reset(0);
    for (int i = 0; i < 4; i++) do_write(6'(8 + 4*i), 32'(i + 1), 4'hF);
    chk("key_literal", aes_key, 128'h00000001_00000002_00000003_00000004);
    for (int i = 0; i < 4; i++) do_read(6'(8 + 4*i), d);
    do_write(6'h18, 32'hAABBCCDD, 4'h5, 3, 0);
    chk("split_b_latency", last_lat, 1);
    do_read(6'h18, d);
    chk("din0_strobed", d, 32'h00BB00DD);
    s0 = starts_seen;
    do_write(6'h00, 32'h3, 4'hF);
    chk("start_pulse", starts_seen - s0, 1);
    chk("mode_literal", aes_mode, 1);
    do_read(6'h04, d);
    chk("status_busy", d, 32'h1);
    core_done(128'h0123456789ABCDEF0123456789ABCDEF);
    do_read(6'h04, d);
    chk("status_done", d, 32'h2);
    do_read(6'h28, d);
    chk("dout0_literal", d, 32'h01234567);
    s0 = starts_seen;
    do_write(6'h00, 32'h1, 4'hF);
    do_write(6'h00, 32'h3, 4'hF);
    chk("start_while_busy", starts_seen - s0, 1);
    chk("mode_while_busy", aes_mode, 1);
    v = {$urandom, $urandom, $urandom, $urandom};
    chk_en = 0;
    fork
      axi_write(6'h04, 32'h2, 4'hF, 0, 0, 0, last_resp, last_lat);
      begin @(negedge clk); aes_done = 1; aes_dout = v; @(negedge clk); aes_done = 0; end
    join
    m_write(6'h04, 32'h2, 4'hF, last_rresp);
    m_done(v);
    chk_en = 1;
    do_read(6'h04, d);
    chk("collision_done", d, 32'h2);
    do_write(6'h04, 32'h2, 4'hF);
    do_read(6'h04, d);
    chk("status_cleared", d, 32'h0);
    do_write(6'h28, 32'hDEADBEEF, 4'hF, 0, 0, 5);
    chk("dout_write_slverr", last_resp, 2'b10);
    do_write(6'h38, 32'h12345678, 4'hF);
    chk("unmapped_write_slverr", last_resp, 2'b10);
    do_read(6'h3C, d, 5);
    chk("unmapped_rdata", d, 0);
    chk("unmapped_rresp", last_rresp, 2'b10);
    do_read(6'h28, d);
`ifdef AES_AXIL_IRQ_EN
    do_write(6'h00, 32'h5, 4'hF);
    chk_en = 0;
    aes_done = 1; aes_dout = v;
    @(negedge clk);
    aes_done = 0;
    chk("irq_not_yet", irq, 0);
    @(negedge clk);
    chk("irq_raised", irq, 1);
    m_done(v);
    chk_en = 1;
    do_write(6'h04, 32'h2, 4'h1);
    chk("irq_cleared", irq, 0);
`endif
    do_write(6'h00, 32'h5, 4'hF);
    do_reset(1);
    do_read(6'h04, d);
    chk("status_after_reset", d, 0);
    chk("irq_after_reset", irq, 0);
    for (int i = 0; i < 250; i++) begin
      int op = $urandom_range(0, 9);
      if (op < 4)
        do_write({4'($urandom_range(0, 15)), 2'($urandom)}, $urandom, 4'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      else if (op < 8) do_read({4'($urandom_range(0, 15)), 2'($urandom)}, d, $urandom_range(0, 2));
      else core_done({$urandom, $urandom, $urandom, $urandom});
    end
    chk("start_count", starts_seen, starts_m);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
